// File: rtl/box_reduce_engine.sv
`default_nettype none
// ============================================================================
// Module   : box_reduce_engine
// Brief    : Multi-level 2x2 box reduction over an external ping-pong RAM.
//            Define BOX_COUNT_EN to enable per-level nonzero-box counting.
// Revision : 1.0 - initial release
// ============================================================================
module box_reduce_engine #(
  parameter int DATA_LEN  = 8,
  parameter int MAX_LEVEL = 3,
  parameter int LVL_W     = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [LVL_W-1:0]       i_n_levels,
  input  logic                   i_mode,
  output logic                   o_rd_en,
  output logic [2*MAX_LEVEL:0]   o_rd_addr,
  input  logic [DATA_LEN-1:0]    i_rd_data,
  output logic                   o_wr_en,
  output logic [2*MAX_LEVEL:0]   o_wr_addr,
  output logic [DATA_LEN-1:0]    o_wr_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_result_bank,
  output logic                   o_lvl_valid,
  output logic [LVL_W-1:0]       o_lvl_idx,
  output logic [2*MAX_LEVEL:0]   o_lvl_count
);

  localparam logic [LVL_W-1:0] c_MAX_LVL = LVL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_DRAIN = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic                   r_src;
  logic                   r_mode;
  logic                   r_result_bank;
  logic [LVL_W-1:0]       r_level;
  logic [LVL_W-1:0]       r_n;
  logic [LVL_W-1:0]       w_n_clamped;
  logic [MAX_LEVEL-1:0]   r_i, r_j;
  logic [MAX_LEVEL-1:0]   w_side_m1;
  logic [MAX_LEVEL-1:0]   w_x, w_y;
  logic [1:0]             r_sub;
  logic                   w_cell_last;
  logic                   w_level_last;

  logic                   r_rd_vld;
  logic [1:0]             r_rd_k;
  logic [MAX_LEVEL-1:0]   r_rd_i, r_rd_j;
  logic [DATA_LEN+1:0]    r_acc;
  logic [DATA_LEN+1:0]    w_comb;
  logic [DATA_LEN-1:0]    w_result;
  logic                   r_wr_en;
  logic [2*MAX_LEVEL:0]   r_wr_addr;
  logic [DATA_LEN-1:0]    r_wr_data;

  assign w_n_clamped = ((i_n_levels == '0) || (i_n_levels > c_MAX_LVL)) ? c_MAX_LVL : i_n_levels;

  // Output side at level L is 2^(MAX_LEVEL-L); this is its last index.
  assign w_side_m1    = {MAX_LEVEL{1'b1}} >> r_level;
  assign w_cell_last  = (r_sub == 2'd3);
  assign w_level_last = w_cell_last && (r_i == w_side_m1) && (r_j == w_side_m1);

  assign w_x = (r_i << 1) | MAX_LEVEL'(r_sub[0]);
  assign w_y = (r_j << 1) | MAX_LEVEL'(r_sub[1]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    o_rd_en = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = S_READ;
      end
      S_READ: begin
        o_rd_en = 1'b1;
        o_busy  = 1'b1;
        if (w_level_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (r_wr_en) w_next = S_NEXT;
      end
      S_NEXT: begin
        o_busy = 1'b1;
        w_next = (r_level == r_n) ? S_DONE : S_READ;
      end
      S_DONE: begin
        o_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src         <= 1'b0;
      r_mode        <= 1'b0;
      r_result_bank <= 1'b0;
      r_level       <= '0;
      r_n           <= '0;
      r_i           <= '0;
      r_j           <= '0;
      r_sub         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_level <= LVL_W'(1);
            r_src   <= 1'b0;
            r_n     <= w_n_clamped;
            r_mode  <= i_mode;
            r_i     <= '0;
            r_j     <= '0;
            r_sub   <= '0;
          end
        end
        S_READ: begin
          r_sub <= r_sub + 2'd1;
          if (w_cell_last) begin
            if (r_i == w_side_m1) begin
              r_i <= '0;
              r_j <= r_j + MAX_LEVEL'(1);
            end else begin
              r_i <= r_i + MAX_LEVEL'(1);
            end
          end
        end
        S_NEXT: begin
          r_src   <= ~r_src;
          r_level <= r_level + LVL_W'(1);
          r_i     <= '0;
          r_j     <= '0;
          r_sub   <= '0;
          if (r_level == r_n) r_result_bank <= r_level[0];
        end
        default: ;
      endcase
    end
  end

  // Sum is formed in DATA_LEN+2 bits so four full-scale cells cannot wrap.
  assign w_comb   = r_mode ? (({2'b00, i_rd_data} > r_acc) ? {2'b00, i_rd_data} : r_acc)
                           : (r_acc + {2'b00, i_rd_data});
  assign w_result = (|w_comb[DATA_LEN+1:DATA_LEN]) ? {DATA_LEN{1'b1}} : w_comb[DATA_LEN-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_k    <= '0;
      r_rd_i    <= '0;
      r_rd_j    <= '0;
      r_acc     <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_rd_vld <= o_rd_en;
      r_rd_k   <= r_sub;
      r_rd_i   <= r_i;
      r_rd_j   <= r_j;
      r_wr_en  <= 1'b0;
      if (r_rd_vld) begin
        case (r_rd_k)
          2'd0: r_acc <= {2'b00, i_rd_data};
          2'd3: begin
            r_wr_en   <= 1'b1;
            r_wr_data <= w_result;
            r_wr_addr <= {~r_src, r_rd_j, r_rd_i};
          end
          default: r_acc <= w_comb;
        endcase
      end
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_wr_data     = r_wr_data;
  assign o_rd_addr     = o_rd_en ? {r_src, w_y, w_x} : '0;
  assign o_result_bank = r_result_bank;

`ifdef BOX_COUNT_EN
  logic                 r_lvl_valid;
  logic [LVL_W-1:0]     r_lvl_idx;
  logic [2*MAX_LEVEL:0] r_lvl_count;
  logic [2*MAX_LEVEL:0] r_cnt;
  logic [2*MAX_LEVEL:0] w_cnt_nxt;
  logic                 w_nz;
  logic                 w_level_end;

  assign w_nz        = r_wr_en && (|r_wr_data);
  assign w_cnt_nxt   = r_cnt + {{(2*MAX_LEVEL){1'b0}}, w_nz};
  // In DRAIN the only write that can appear is the level's final one.
  assign w_level_end = (r_state == S_DRAIN) && r_wr_en;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lvl_valid <= 1'b0;
      r_lvl_idx   <= '0;
      r_lvl_count <= '0;
      r_cnt       <= '0;
    end else begin
      r_lvl_valid <= 1'b0;
      if (w_level_end) begin
        r_lvl_valid <= 1'b1;
        r_lvl_idx   <= r_level;
        r_lvl_count <= w_cnt_nxt;
        r_cnt       <= '0;
      end else begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign o_lvl_valid = r_lvl_valid;
  assign o_lvl_idx   = r_lvl_idx;
  assign o_lvl_count = r_lvl_count;
`else
  assign o_lvl_valid = 1'b0;
  assign o_lvl_idx   = '0;
  assign o_lvl_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_box_reduce_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_box_reduce_engine
// Brief    : Directed self-checking bench for box_reduce_engine with a
//            two-bank, 1-cycle-latency RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_box_reduce_engine;

  localparam int DL = 8;
  localparam int ML = 3;
  localparam int LW = 2;
  localparam int AL = 2*ML+1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] n_levels = '0;
  logic          mode = 1'b0;
  logic          rd_en, wr_en, busy, done, result_bank, lvl_valid;
  logic [AL-1:0] rd_addr, wr_addr, lvl_count;
  logic [DL-1:0] rd_data = '0;
  logic [DL-1:0] wr_data;
  logic [LW-1:0] lvl_idx;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  box_reduce_engine #(.DATA_LEN(DL), .MAX_LEVEL(ML), .LVL_W(LW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_n_levels   (n_levels),
    .i_mode       (mode),
    .o_rd_en      (rd_en),
    .o_rd_addr    (rd_addr),
    .i_rd_data    (rd_data),
    .o_wr_en      (wr_en),
    .o_wr_addr    (wr_addr),
    .o_wr_data    (wr_data),
    .o_busy       (busy),
    .o_done       (done),
    .o_result_bank(result_bank),
    .o_lvl_valid  (lvl_valid),
    .o_lvl_idx    (lvl_idx),
    .o_lvl_count  (lvl_count)
  );

  // RAM model: bank 1 always preloaded with zeros.
  logic [DL-1:0] mem [0:127];
  logic          load = 1'b0;
  int            pat = 0;

  function automatic logic [DL-1:0] pat_val(int p, int a);
    if (a >= 64) return '0;
    case (p)
      0: return 8'd1;
      1: return 8'd100;
      2: return DL'(a);
      3: return (a == 21) ? 8'd7 : 8'd0;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 128; a++) mem[a] <= pat_val(pat, a);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) rd_data <= mem[rd_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wa_q[$], wd_q[$], wc_q[$], li_q[$], lc_q[$];
  int first_rd = -1, first_rd_b1 = -1, done_cnt = 0, coll_cnt = 0;
  int t_start = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(int'(wr_addr));
      wd_q.push_back(int'(wr_data));
      wc_q.push_back(cyc);
    end
    if (rd_en && first_rd < 0) first_rd = cyc;
    if (rd_en && rd_addr[AL-1] && first_rd_b1 < 0) first_rd_b1 = cyc;
    if (done) done_cnt++;
    if (rd_en && wr_en && (rd_addr[AL-1] == wr_addr[AL-1])) coll_cnt++;
    if (lvl_valid) begin
      li_q.push_back(int'(lvl_idx));
      lc_q.push_back(int'(lvl_count));
    end
  end

  task automatic clear_logs;
    wa_q.delete(); wd_q.delete(); wc_q.delete(); li_q.delete(); lc_q.delete();
    first_rd = -1; first_rd_b1 = -1; done_cnt = 0; coll_cnt = 0;
  endtask

  task automatic load_mem(input int p);
    @(negedge clk); pat = p; load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic launch(input logic [LW-1:0] n, input logic m);
    clear_logs();
    @(negedge clk); start = 1'b1; n_levels = n; mode = m; t_start = cyc;
    @(negedge clk); start = 1'b0; n_levels = ~n; mode = ~m;
    #1;
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL busy_after_start got %b want 1", busy); end
  endtask

  task automatic run_job(input logic [LW-1:0] n, input logic m, input int glitch);
    launch(n, m);
    if (glitch > 0) begin
      repeat (glitch) @(negedge clk);
      start = 1'b1; n_levels = 2'd3; mode = ~m;
      @(negedge clk); start = 1'b0;
    end
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin @(negedge clk); #1; end
    nvec++;
    if (done_cnt == 0) begin nerr++; $display("FAIL done_timeout got 0 pulses want 1"); end
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    nvec++;
    if ({rd_en, wr_en, busy, done} !== 4'b0) begin
      nerr++; $display("FAIL reset_ctrl got %b want 0000", {rd_en, wr_en, busy, done});
    end
    nvec++;
    if ({rd_addr, wr_addr, wr_data} !== '0) begin
      nerr++; $display("FAIL reset_bus got %h want 0", {rd_addr, wr_addr, wr_data});
    end
    nvec++;
    if ({result_bank, lvl_valid, lvl_idx, lvl_count} !== '0) begin
      nerr++; $display("FAIL reset_status got %h want 0", {result_bank, lvl_valid, lvl_idx, lvl_count});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sum_full;
    int ea, ed;
    int lc_exp [3];
    lc_exp[0] = 16; lc_exp[1] = 4; lc_exp[2] = 1;
    load_mem(0);
    run_job(2'd3, 1'b0, 0);
    nvec++;
    if (first_rd !== t_start + 1) begin nerr++; $display("FAIL first_rd_latency got %0d want %0d", first_rd, t_start + 1); end
    nvec++;
    if (wa_q.size() != 21) begin
      nerr++; $display("FAIL sum_full_count got %0d want 21", wa_q.size());
    end else begin
      for (int k = 0; k < 21; k++) begin
        if (k < 16) begin ea = 64 + (k/4)*8 + k%4; ed = 4; end
        else if (k < 20) begin ea = ((k-16)/2)*8 + (k-16)%2; ed = 16; end
        else begin ea = 64; ed = 64; end
        nvec++;
        if (wa_q[k] !== ea || wd_q[k] !== ed) begin
          nerr++; $display("FAIL sum_full_wr%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa_q[k], wd_q[k], ea, ed);
        end
      end
      for (int k = 1; k < 16; k++) begin
        nvec++;
        if (wc_q[k] - wc_q[k-1] !== 4) begin
          nerr++; $display("FAIL l1_spacing%0d got %0d want 4", k, wc_q[k] - wc_q[k-1]);
        end
      end
      nvec++;
      if (!(first_rd_b1 > wc_q[15])) begin
        nerr++; $display("FAIL level_boundary got rd@%0d want after wr@%0d", first_rd_b1, wc_q[15]);
      end
    end
    nvec++;
    if (done_cnt !== 1) begin nerr++; $display("FAIL sum_full_done got %0d want 1", done_cnt); end
    nvec++;
    if (result_bank !== 1'b1) begin nerr++; $display("FAIL sum_full_bank got %b want 1", result_bank); end
    nvec++;
    if (coll_cnt !== 0) begin nerr++; $display("FAIL bank_collision got %0d want 0", coll_cnt); end
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL busy_after_done got %b want 0", busy); end
`ifdef BOX_COUNT_EN
    nvec++;
    if (li_q.size() != 3) begin
      nerr++; $display("FAIL lvl_pulses got %0d want 3", li_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (li_q[k] !== k + 1 || lc_q[k] !== lc_exp[k]) begin
          nerr++; $display("FAIL lvl%0d got idx=%0d cnt=%0d want idx=%0d cnt=%0d", k, li_q[k], lc_q[k], k + 1, lc_exp[k]);
        end
      end
    end
`else
    nvec++;
    if (li_q.size() != 0 || lvl_idx !== '0 || lvl_count !== '0) begin
      nerr++; $display("FAIL lvl_tied got pulses=%0d idx=%0d cnt=%0d want 0", li_q.size(), lvl_idx, lvl_count);
    end
`endif
  endtask

  task automatic test_saturate;
    load_mem(1);
    run_job(2'd1, 1'b0, 0);
    nvec++;
    if (wa_q.size() != 16) begin
      nerr++; $display("FAIL sat_count got %0d want 16", wa_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        nvec++;
        if (wd_q[k] !== 255) begin nerr++; $display("FAIL sat_wr%0d got %0d want 255", k, wd_q[k]); end
      end
    end
    nvec++;
    if (result_bank !== 1'b1) begin nerr++; $display("FAIL sat_bank got %b want 1", result_bank); end
  endtask

  task automatic test_max;
    int ed;
    int l2 [4];
    l2[0] = 27; l2[1] = 31; l2[2] = 59; l2[3] = 63;
    load_mem(2);
    run_job(2'd2, 1'b1, 0);
    nvec++;
    if (wa_q.size() != 20) begin
      nerr++; $display("FAIL max_count got %0d want 20", wa_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        ed = 8*(2*(k/4)+1) + (2*(k%4)+1);
        nvec++;
        if (wd_q[k] !== ed) begin nerr++; $display("FAIL max_l1_wr%0d got %0d want %0d", k, wd_q[k], ed); end
      end
      for (int k = 0; k < 4; k++) begin
        nvec++;
        if (wa_q[16+k] !== (k/2)*8 + k%2 || wd_q[16+k] !== l2[k]) begin
          nerr++; $display("FAIL max_l2_wr%0d got a=%0d d=%0d want a=%0d d=%0d", k, wa_q[16+k], wd_q[16+k], (k/2)*8 + k%2, l2[k]);
        end
      end
    end
    nvec++;
    if (result_bank !== 1'b0) begin nerr++; $display("FAIL max_bank got %b want 0", result_bank); end
  endtask

  task automatic test_single_clamp;
    int nz_a[$], nz_d[$];
    int ea [3];
    ea[0] = 74; ea[1] = 1; ea[2] = 64;
    load_mem(3);
    run_job(2'd0, 1'b0, 0);
    nvec++;
    if (wa_q.size() != 21) begin nerr++; $display("FAIL clamp_count got %0d want 21", wa_q.size()); end
    for (int k = 0; k < wa_q.size(); k++) begin
      if (wd_q[k] != 0) begin nz_a.push_back(wa_q[k]); nz_d.push_back(wd_q[k]); end
    end
    nvec++;
    if (nz_a.size() != 3) begin
      nerr++; $display("FAIL single_nz_count got %0d want 3", nz_a.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        nvec++;
        if (nz_a[k] !== ea[k] || nz_d[k] !== 7) begin
          nerr++; $display("FAIL single_nz%0d got a=%0d d=%0d want a=%0d d=7", k, nz_a[k], nz_d[k], ea[k]);
        end
      end
    end
`ifdef BOX_COUNT_EN
    nvec++;
    if (lc_q.size() != 3 || lc_q[0] !== 1 || lc_q[1] !== 1 || lc_q[2] !== 1) begin
      nerr++; $display("FAIL single_lvl_count got n=%0d want 3 pulses of 1", lc_q.size());
    end
`endif
  endtask

  task automatic test_midrun_start;
    load_mem(0);
    run_job(2'd1, 1'b0, 20);
    nvec++;
    if (wa_q.size() != 16) begin
      nerr++; $display("FAIL midrun_count got %0d want 16", wa_q.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        nvec++;
        if (wd_q[k] !== 4 || wa_q[k] !== 64 + (k/4)*8 + k%4) begin
          nerr++; $display("FAIL midrun_wr%0d got a=%0d d=%0d want a=%0d d=4", k, wa_q[k], wd_q[k], 64 + (k/4)*8 + k%4);
        end
      end
    end
    nvec++;
    if (done_cnt !== 1) begin nerr++; $display("FAIL midrun_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_abort;
    int nw;
    load_mem(0);
    launch(2'd3, 1'b0);
    for (int k = 0; k < 2000 && first_rd_b1 < 0; k++) begin @(negedge clk); #1; end
    nvec++;
    if (first_rd_b1 < 0) begin nerr++; $display("FAIL abort_reach_l2 got no level-2 read want one"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    nw = wa_q.size();
    @(negedge clk); #1;
    nvec++;
    if ({rd_en, wr_en, busy, done, result_bank, lvl_valid} !== 6'b0 || {rd_addr, wr_addr, wr_data, lvl_idx, lvl_count} !== '0) begin
      nerr++; $display("FAIL abort_outputs got ctl=%b bus=%h want 0", {rd_en, wr_en, busy, done, result_bank, lvl_valid},
                       {rd_addr, wr_addr, wr_data, lvl_idx, lvl_count});
    end
    repeat (3) @(negedge clk);
    #1;
    nvec++;
    if (wa_q.size() !== nw || done_cnt !== 0) begin
      nerr++; $display("FAIL abort_quiet got writes=%0d done=%0d want writes=%0d done=0", wa_q.size(), done_cnt, nw);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    load_mem(0);
    run_job(2'd1, 1'b0, 0);
    nvec++;
    if (first_rd !== t_start + 1) begin nerr++; $display("FAIL restart_latency got %0d want %0d", first_rd, t_start + 1); end
    nvec++;
    if (wa_q.size() != 16) begin
      nerr++; $display("FAIL restart_count got %0d want 16", wa_q.size());
    end else begin
      nvec++;
      if (wa_q[0] !== 64 || wd_q[0] !== 4 || wa_q[15] !== 64 + 27 || wd_q[15] !== 4) begin
        nerr++; $display("FAIL restart_data got a0=%0d d0=%0d a15=%0d d15=%0d want 64 4 91 4", wa_q[0], wd_q[0], wa_q[15], wd_q[15]);
      end
    end
    nvec++;
    if (done_cnt !== 1 || result_bank !== 1'b1) begin
      nerr++; $display("FAIL restart_done got done=%0d bank=%b want 1 1", done_cnt, result_bank);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sum_full();
    test_saturate();
    test_max();
    test_single_clamp();
    test_midrun_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
